// File: rtl/write_resp_gen_if.sv
// B-channel generator bundle: AW/W completion strobes in, B response and FIFO status out.
// Latency: n/a (wires only).
// Backpressure: B_ready from downstream; AW_Full/W_Full tell upstream to drop AWREADY/WREADY.
interface write_resp_gen_if #(
    parameter int Masters_Id_Size = 1,
    parameter int Depth           = 4
);
    logic                         AW_Fire;
    logic [Masters_Id_Size-1:0]   AW_ID;
    logic                         AW_Decerr;
    logic                         W_Last_Fire;
    logic                         W_Slverr;
    logic                         AW_Full;
    logic                         W_Full;
    logic [Masters_Id_Size-1:0]   B_ID;
    logic [1:0]                   B_resp;
    logic                         B_valid;
    logic                         B_ready;
    logic [$clog2(Depth+1)-1:0]   Pending_Cnt;

    modport master (
        output AW_Fire, AW_ID, AW_Decerr, W_Last_Fire, W_Slverr, B_ready,
        input  AW_Full, W_Full, B_ID, B_resp, B_valid, Pending_Cnt
    );

    modport slave (
        input  AW_Fire, AW_ID, AW_Decerr, W_Last_Fire, W_Slverr, B_ready,
        output AW_Full, W_Full, B_ID, B_resp, B_valid, Pending_Cnt
    );
endinterface

// File: rtl/write_resp_gen.sv
// Generic FIFO and AXI4 slave write-response generator pairing AW info with completed W bursts.
// Latency: head visible one cycle after push (no bypass); B_valid two cycles after the later fire.
// Backpressure: B_ready stalls the output slot; full FIFOs drop pushes unless popped that edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_dat,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head_dat,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign pop_ok   = pop && !empty;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign push_ok  = push && (!full || pop_ok);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module write_resp_gen #(
    parameter int Masters_Id_Size = 1,
    parameter int Depth           = 4
) (
    input  logic           clk,
    input  logic           rst,
    write_resp_gen_if.slave bus
);
    localparam int CW = $clog2(Depth+1);

    logic [Masters_Id_Size:0]  aw_head;
    logic [CW-1:0]             aw_count;
    logic                      aw_empty;
    logic                      w_head;
    logic [CW-1:0]             w_count;
    logic                      w_empty;
    logic                      slot_free;
    logic                      load;

    assign slot_free = !bus.B_valid || bus.B_ready;
    assign load      = slot_free && !aw_empty && !w_empty;

    sync_fifo #(
        .WIDTH (Masters_Id_Size + 1),
        .DEPTH (Depth)
    ) u_aw_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (bus.AW_Fire),
        .push_dat ({bus.AW_ID, bus.AW_Decerr}),
        .pop      (load),
        .head_dat (aw_head),
        .count    (aw_count),
        .full     (bus.AW_Full),
        .empty    (aw_empty)
    );

    sync_fifo #(
        .WIDTH (1),
        .DEPTH (Depth)
    ) u_w_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (bus.W_Last_Fire),
        .push_dat (bus.W_Slverr),
        .pop      (load),
        .head_dat (w_head),
        .count    (w_count),
        .full     (bus.W_Full),
        .empty    (w_empty)
    );

    assign bus.Pending_Cnt = aw_count;

    // Output slot: ID/resp only change on a load, so they hold while B_ready is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.B_valid <= 1'b0;
            bus.B_ID    <= '0;
            bus.B_resp  <= 2'b00;
        end else if (load) begin
            bus.B_valid <= 1'b1;
            bus.B_ID    <= aw_head[Masters_Id_Size:1];
            bus.B_resp  <= aw_head[0] ? 2'b11 : (w_head ? 2'b10 : 2'b00);
        end else if (bus.B_ready) begin
            bus.B_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_write_resp_gen.sv
// Bench for write_resp_gen: directed scenarios plus random stream against a queue-based model.
// Outputs are compared every negedge and at directed points one time unit after posedge.
module tb_write_resp_gen;
    localparam int ID_W  = 3;
    localparam int DEPTH = 4;

    logic clk;
    logic rst;
    int   vecs;
    int   errs;

    write_resp_gen_if #(.Masters_Id_Size(ID_W), .Depth(DEPTH)) bus ();

    write_resp_gen #(.Masters_Id_Size(ID_W), .Depth(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        vecs++;
        if (obs !== 32'(exp)) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: AW info and W status queues plus one response slot.
    typedef struct packed {
        logic [ID_W-1:0] id;
        logic            dec;
    } aw_t;

    aw_t        aw_q[$];
    bit         w_q[$];
    bit         m_valid;
    int         m_id;
    int         m_resp;
    bit         m_pop;
    aw_t        aw_new;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            aw_q.delete();
            w_q.delete();
            m_valid = 1'b0;
        end else begin
            // Load decision uses only entries present before this edge.
            m_pop = (!m_valid || bus.B_ready) && aw_q.size() > 0 && w_q.size() > 0;
            if (m_pop) begin
                m_valid = 1'b1;
                m_id    = int'(aw_q[0].id);
                m_resp  = aw_q[0].dec ? 3 : (w_q[0] ? 2 : 0);
                void'(aw_q.pop_front());
                void'(w_q.pop_front());
            end else if (bus.B_ready) begin
                m_valid = 1'b0;
            end
            if (bus.AW_Fire && aw_q.size() < DEPTH) begin
                aw_new.id  = bus.AW_ID;
                aw_new.dec = bus.AW_Decerr;
                aw_q.push_back(aw_new);
            end
            if (bus.W_Last_Fire && w_q.size() < DEPTH) begin
                w_q.push_back(bus.W_Slverr);
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("b_valid", bus.B_valid, int'(m_valid));
            if (m_valid) begin
                chk("b_id", bus.B_ID, m_id);
                chk("b_resp", bus.B_resp, m_resp);
            end
            chk("pending", bus.Pending_Cnt, aw_q.size());
            chk("aw_full", bus.AW_Full, int'(aw_q.size() == DEPTH));
            chk("w_full", bus.W_Full, int'(w_q.size() == DEPTH));
        end
    end

    task automatic step(input bit aw, input int id, input bit dec,
                        input bit w, input bit slv, input bit rdy);
        bus.AW_Fire     = aw;
        bus.AW_ID       = ID_W'(id);
        bus.AW_Decerr   = dec;
        bus.W_Last_Fire = w;
        bus.W_Slverr    = slv;
        bus.B_ready     = rdy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  id_ctr;
        bit  a;
        bit  w;
        vecs = 0;
        errs = 0;
        rst  = 1'b0;
        bus.AW_Fire = 0; bus.AW_ID = '0; bus.AW_Decerr = 0;
        bus.W_Last_Fire = 0; bus.W_Slverr = 0; bus.B_ready = 0;
        #12;
        chk("rst_valid", bus.B_valid, 0);
        chk("rst_id", bus.B_ID, 0);
        chk("rst_resp", bus.B_resp, 0);
        chk("rst_awfull", bus.AW_Full, 0);
        chk("rst_wfull", bus.W_Full, 0);
        chk("rst_pending", bus.Pending_Cnt, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // T1: both fires in cycle 0 -> response in cycle 2 only
        step(1, 1, 0, 1, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        chk("t1_valid", bus.B_valid, 1);
        chk("t1_id", bus.B_ID, 1);
        chk("t1_resp", bus.B_resp, 0);
        step(0, 0, 0, 0, 0, 1);
        chk("t1_drop", bus.B_valid, 0);

        // T2: W first, AW five cycles later; the later fire sets timing
        for (int c = 0; c < 8; c++) begin
            if (c > 0) chk("t2_valid", bus.B_valid, int'(c == 7));
            if (c == 7) begin
                chk("t2_id", bus.B_ID, 0);
                chk("t2_resp", bus.B_resp, 2);
            end
            step(c == 5, 0, 0, c == 0, 1, 1);
        end

        // T3: DECERR wins over SLVERR and holds while stalled
        step(1, 1, 1, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 4; c++) begin
            chk("t3_valid", bus.B_valid, 1);
            chk("t3_id", bus.B_ID, 1);
            chk("t3_resp", bus.B_resp, 3);
            step(0, 0, 0, 0, 0, 0);
        end
        chk("t3_hold", bus.B_valid, 1);
        step(0, 0, 0, 0, 0, 1);
        chk("t3_accept", bus.B_valid, 0);

        // T4: fill to Depth, overflow push dropped, then back-to-back drain
        for (int k = 0; k < 4; k++) step(1, k, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("t4_pend3", bus.Pending_Cnt, 3);
        chk("t4_notfull", bus.AW_Full, 0);
        chk("t4_slot_id", bus.B_ID, 0);
        step(1, 4, 0, 1, 0, 0);
        chk("t4_pend4", bus.Pending_Cnt, 4);
        chk("t4_awfull", bus.AW_Full, 1);
        chk("t4_wfull", bus.W_Full, 1);
        step(1, 5, 0, 0, 0, 0);
        chk("t4_dropped", bus.Pending_Cnt, 4);
        for (int k = 0; k < 5; k++) begin
            chk("t4_drain_valid", bus.B_valid, 1);
            chk("t4_drain_id", bus.B_ID, k);
            step(0, 0, 0, 0, 0, 1);
        end
        chk("t4_empty", bus.B_valid, 0);
        chk("t4_pend0", bus.Pending_Cnt, 0);

        // T5: random stream, occasional pushes into a full FIFO
        id_ctr = 0;
        for (int c = 0; c < 800; c++) begin
            a = ($urandom_range(0, 2) != 0) && (!bus.AW_Full || $urandom_range(0, 1) == 1);
            w = ($urandom_range(0, 2) != 0) && (!bus.W_Full || $urandom_range(0, 1) == 1);
            step(a, id_ctr & 1, $urandom_range(0, 3) == 0, w, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 1) == 1);
            if (a) id_ctr++;
        end
        for (int c = 0; c < 12; c++) step(0, 0, 0, 0, 0, 1);
        // Unmatched W entries may linger; clear them with matching AWs.
        for (int c = 0; c < 6; c++) step(1, 0, 0, 0, 0, 1);
        for (int c = 0; c < 6; c++) step(0, 0, 0, 1, 0, 1);
        for (int c = 0; c < 6; c++) step(0, 0, 0, 0, 0, 1);
        rst = 1'b0;
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // T6: async reset mid-handshake discards slot and pending entries
        step(1, 1, 0, 1, 0, 0);
        step(1, 2, 0, 1, 0, 0);
        step(1, 3, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("t6_pre_valid", bus.B_valid, 1);
        chk("t6_pre_pend", bus.Pending_Cnt, 2);
        #2 rst = 1'b0;
        #1;
        chk("t6_rst_valid", bus.B_valid, 0);
        chk("t6_rst_pend", bus.Pending_Cnt, 0);
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
        step(1, 6, 0, 1, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        chk("t6_new_valid", bus.B_valid, 1);
        chk("t6_new_id", bus.B_ID, 6);
        step(0, 0, 0, 0, 0, 1);
        chk("t6_no_old", bus.B_valid, 0);
        step(0, 0, 0, 0, 0, 1);
        chk("t6_still_idle", bus.B_valid, 0);
        chk("t6_pend", bus.Pending_Cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
